// File: rtl/mont_mul_gen_pkg.sv
// Shared types and limits for the radix-2 Montgomery multiplier.
package mont_mul_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOP,
        S_SUB,
        S_ERR,
        S_DONE
    } mont_state_e;

    localparam int unsigned MONT_MAX_WIDTH = 4096;

endpackage

// File: rtl/mont_mul_gen_if.sv
// Request/response bundle between the exponentiation controller and the multiplier.
interface mont_mul_gen_if #(
    parameter int unsigned WIDTH = 256
);
    logic             i_start;
    logic [WIDTH-1:0] i_n;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] o_result;
    logic             o_end;
    logic             o_err;
    logic             o_busy;

    modport master (
        output i_start, i_n, i_a, i_b,
        input  o_result, o_end, o_err, o_busy
    );

    modport slave (
        input  i_start, i_n, i_a, i_b,
        output o_result, o_end, o_err, o_busy
    );
endinterface

// File: rtl/mont_mul_gen_step.sv
// One radix-2 Montgomery iteration: (acc + a_bit*b, made even by adding n) / 2.
module mont_mul_gen_step #(
    parameter int unsigned WIDTH = 256
) (
    input  logic [WIDTH+1:0] acc_i,
    input  logic             a_bit_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH+1:0] acc_next_o
);
    logic [WIDTH+1:0] t_add_b;
    logic [WIDTH+1:0] t_add_n;

    // acc < 2n keeps acc + b + n below 4n, so WIDTH+2 bits never overflow
    always_comb begin
        t_add_b    = acc_i + (a_bit_i ? {2'b00, b_i} : '0);
        t_add_n    = t_add_b + (t_add_b[0] ? {2'b00, n_i} : '0);
        acc_next_o = {1'b0, t_add_n[WIDTH+1:1]};
    end
endmodule

// File: rtl/mont_mul_gen.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod n, one bit of a per cycle.
module mont_mul_gen
    import mont_mul_gen_pkg::*;
#(
    parameter int unsigned WIDTH     = 256,
    parameter bit          FINAL_SUB = 1'b1,
    parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    mont_mul_gen_if.slave bus
);
    if (WIDTH < 4 || WIDTH > MONT_MAX_WIDTH) begin : g_bad_width
        $error("mont_mul_gen: WIDTH out of range");
    end

    mont_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH+1:0] acc_q;
    logic [WIDTH+1:0] acc_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] result_q;
    logic             end_q;
    logic             err_q;
    logic             busy_q;
    logic [WIDTH+1:0] ext_n;

    assign ext_n = {2'b00, n_q};

    mont_mul_gen_step #(.WIDTH(WIDTH)) u_step (
        .acc_i      (acc_q),
        .a_bit_i    (a_q[0]),
        .b_i        (b_q),
        .n_i        (n_q),
        .acc_next_o (acc_d)
    );

    // a_q is shifted right each iteration so the current multiplier bit is always a_q[0]
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            end_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            end_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        a_q     <= bus.i_a;
                        b_q     <= bus.i_b;
                        n_q     <= bus.i_n;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= bus.i_n[0] ? S_LOOP : S_ERR;
                    end
                end
                S_LOOP: begin
                    acc_q <= acc_d;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_SUB;
                    end
                end
                S_SUB: begin
                    result_q <= WIDTH'((FINAL_SUB && (acc_q >= ext_n)) ? acc_q - ext_n : acc_q);
                    end_q    <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_ERR: begin
                    result_q <= '0;
                    end_q    <= 1'b1;
                    err_q    <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_end    = end_q;
    assign bus.o_err    = err_q;
    assign bus.o_busy   = busy_q;
endmodule

// File: tb/tb_mont_mul_gen.sv
// Scoreboard bench: a reduced 8-bit instance and an unreduced 16-bit instance against an arithmetic model.
module tb_mont_mul_gen;
    localparam int unsigned W1 = 8;
    localparam int unsigned W2 = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mont_mul_gen_if #(.WIDTH(W1)) bus1 ();
    mont_mul_gen_if #(.WIDTH(W2)) bus2 ();

    mont_mul_gen #(.WIDTH(W1), .FINAL_SUB(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));
    mont_mul_gen #(.WIDTH(W2), .FINAL_SUB(1'b0)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2.slave));

    typedef struct {
        longint unsigned res;
        longint unsigned n;
        bit              err;
        int unsigned     end_cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // a*b*R^-1 mod n, with R^-1 = (2^-1)^w and 2^-1 = (n+1)/2 for odd n
    function automatic longint unsigned mont_ref(longint unsigned a, longint unsigned b,
                                                 longint unsigned n, int unsigned w);
        longint unsigned h, rinv, p;
        if (n == 1) return 0;
        h    = (n + 1) / 2;
        rinv = 1;
        for (int i = 0; i < int'(w); i++) rinv = (rinv * h) % n;
        p = ((a % n) * (b % n)) % n;
        return (p * rinv) % n;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint unsigned rand_odd(input int unsigned max_half);
        return 2 * longint'($urandom_range(max_half, 0)) + 1;
    endfunction

    task automatic wait_idle1();
        int k = 0;
        while (bus1.o_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle1_timeout", longint'(k < 200), 1);
    endtask

    task automatic wait_idle2();
        int k = 0;
        while (bus2.o_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle2_timeout", longint'(k < 200), 1);
    endtask

    task automatic push1(input longint unsigned a, input longint unsigned b, input longint unsigned n);
        exp_t e;
        e.n       = n;
        e.err     = (n % 2 == 0);
        e.res     = e.err ? 0 : mont_ref(a, b, n, W1);
        e.end_cyc = cyc + (e.err ? 2 : W1 + 2);
        q1.push_back(e);
    endtask

    task automatic issue1(input longint unsigned a, input longint unsigned b, input longint unsigned n);
        wait_idle1();
        bus1.i_a     = W1'(a);
        bus1.i_b     = W1'(b);
        bus1.i_n     = W1'(n);
        bus1.i_start = 1'b1;
        push1(a, b, n);
        @(negedge clk);
        bus1.i_start = 1'b0;
        bus1.i_a     = W1'($urandom);
        bus1.i_b     = W1'($urandom);
        bus1.i_n     = W1'($urandom);
    endtask

    task automatic issue2(input longint unsigned a, input longint unsigned b, input longint unsigned n);
        exp_t e;
        wait_idle2();
        bus2.i_a     = W2'(a);
        bus2.i_b     = W2'(b);
        bus2.i_n     = W2'(n);
        bus2.i_start = 1'b1;
        e.n       = n;
        e.err     = 1'b0;
        e.res     = mont_ref(a, b, n, W2);
        e.end_cyc = cyc + W2 + 2;
        q2.push_back(e);
        @(negedge clk);
        bus2.i_start = 1'b0;
    endtask

    // Reduced instance: exact result, error flag and end timing
    always @(negedge clk) begin
        if (!rst && bus1.o_end) begin
            if (q1.size() == 0) begin
                check("unexpected_end1", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("result1", bus1.o_result, e.res);
                check("err1", bus1.o_err, e.err);
                check("latency1", cyc, e.end_cyc);
            end
        end else if (!rst && bus1.o_err) begin
            check("err_without_end1", 1, 0);
        end
    end

    // Unreduced instance: result congruent mod n and below 2n
    always @(negedge clk) begin
        if (!rst && bus2.o_end) begin
            if (q2.size() == 0) begin
                check("unexpected_end2", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("result2_mod_n", longint'(bus2.o_result) % e.n, e.res);
                check("result2_below_2n", longint'(longint'(bus2.o_result) < 2 * e.n), 1);
                check("err2", bus2.o_err, 0);
                check("latency2", cyc, e.end_cyc);
            end
        end
    end

    initial begin
        longint unsigned a, b, n;
        bus1.i_start = 1'b0; bus1.i_a = '0; bus1.i_b = '0; bus1.i_n = '0;
        bus2.i_start = 1'b0; bus2.i_a = '0; bus2.i_b = '0; bus2.i_n = '0;

        repeat (3) @(negedge clk);
        check("rst_result1", bus1.o_result, 0);
        check("rst_end1", bus1.o_end, 0);
        check("rst_err1", bus1.o_err, 0);
        check("rst_busy1", bus1.o_busy, 0);
        check("rst_busy2", bus2.o_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // directed vectors, n=13: R mod n = 9, R^-1 mod n = 3
        issue1(1, 1, 13);
        issue1(9, 5, 13);
        issue1(0, 7, 13);
        issue1(5, 3, 12);
        issue1(0, 0, 1);
        issue1(12, 12, 13);
        issue1(254, 253, 255);

        for (int j = 0; j < 12; j++) begin
            n = ($urandom_range(7, 0) == 0) ? 2 * longint'($urandom_range(127, 1)) : rand_odd(127);
            a = $urandom % n;
            b = $urandom % n;
            issue1(a, b, n);
        end

        // start held high with operands churning; only accept-edge operands matter
        wait_idle1();
        for (int j = 0; j < 4 * int'(W1 + 3); j++) begin
            if (j % int'(W1 + 3) == 0) n = rand_odd(127);
            else n = longint'($urandom_range(255, 0));
            a = (n == 0) ? 0 : $urandom % n;
            b = (n == 0) ? 0 : $urandom % n;
            bus1.i_a     = W1'(a);
            bus1.i_b     = W1'(b);
            bus1.i_n     = W1'(n);
            bus1.i_start = 1'b1;
            if (j % int'(W1 + 3) == 0) push1(a, b, n);
            @(negedge clk);
        end
        bus1.i_start = 1'b0;

        // leave a nonzero result, then abort a job at iteration cnt=4
        issue1(12, 12, 13);
        wait_idle1();
        bus1.i_a = W1'(7); bus1.i_b = W1'(11); bus1.i_n = W1'(13);
        bus1.i_start = 1'b1;
        @(negedge clk);
        bus1.i_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_result1", bus1.o_result, 0);
        check("abort_end1", bus1.o_end, 0);
        check("abort_err1", bus1.o_err, 0);
        check("abort_busy1", bus1.o_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        issue1(9, 5, 13);

        // unreduced 16-bit instance, n <= 2^15 so results fit
        issue2(0, 1234, 32767);
        issue2(32766, 32765, 32767);
        for (int j = 0; j < 8; j++) begin
            n = rand_odd(16383);
            a = $urandom % n;
            b = $urandom % n;
            issue2(a, b, n);
        end

        for (int k = 0; k < 300 && (q1.size() != 0 || q2.size() != 0); k++) @(negedge clk);
        check("drain_q1", q1.size(), 0);
        check("drain_q2", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
